// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle between the bus arbiter and its requesters.
//   NUM_REQ  : number of requesters (2..8)
//   req      : per-requester request level, held until served
//   lock     : owner keeps the bus past done for back-to-back accesses
//   done     : one-cycle pulse from the owner when its transfer ends
//   gnt      : registered one-hot grant, zero when the bus has no owner
//   gnt_id   : index of the current owner, zero when gnt is zero
//   bus_busy : high exactly while gnt is non-zero
//   timeout  : one-cycle pulse after a grant is forcibly revoked
// Modport master is the arbiter side (drives the grant); slave is the requester side.
interface bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] lock;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               bus_busy;
  logic               timeout;

  modport master (
    input  req, lock, done,
    output gnt, gnt_id, bus_busy, timeout
  );

  modport slave (
    output req, lock, done,
    input  gnt, gnt_id, bus_busy, timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner sequencing for the shared internal MAR/RAM bus.
// Requester 0 is the CPU controller; the rest are loader, DMA and debug masters.
// Every ownership change passes through a one-cycle dead TURN state so two
// masters never drive the bus in the same cycle.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bus_arbiter_if.master (req/lock/done in, gnt/gnt_id/bus_busy/timeout out)
// Optional feature macro BUS_ARB_TIMEOUT_EN: when defined, a hold counter
// revokes any grant after MAX_HOLD cycles and pulses timeout; otherwise a grant
// lasts until done without lock or a request drop, and timeout stays 0.
module bus_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_arbiter_if.master    bus
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time parameter range checks.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("bus_arbiter: NUM_REQ must be 2..8");
  end
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
  logic [ID_W-1:0]    id_q, id_nxt;
  logic               busy_q, busy_nxt;
  logic               to_q, to_nxt;
  logic [ID_W-1:0]    ptr_q, ptr_nxt;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0]  hold_q, hold_nxt;
`endif

  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic               rel_norm;
  logic               rel_to;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!win_vld && bus.req[ID_W'(idx)]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  // Owner-only release terms; other requesters' done/lock/req are ignored here.
  always_comb begin
    rel_norm = (bus.done[id_q] && !bus.lock[id_q]) || !bus.req[id_q];
`ifdef BUS_ARB_TIMEOUT_EN
    rel_to   = (hold_q == HOLD_W'(MAX_HOLD - 1));
`else
    rel_to   = 1'b0;
`endif
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      ptr_q   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      id_q    <= id_nxt;
      busy_q  <= busy_nxt;
      to_q    <= to_nxt;
      ptr_q   <= ptr_nxt;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q  <= hold_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = gnt_q;
    id_nxt    = id_q;
    busy_nxt  = busy_q;
    to_nxt    = 1'b0;
    ptr_nxt   = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_nxt  = hold_q;
`endif
    case (state_q)
      IDLE, TURN: begin
        if (win_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = NUM_REQ'(1) << win_id;
          id_nxt    = win_id;
          busy_nxt  = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_nxt  = '0;
`endif
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          id_nxt    = '0;
          busy_nxt  = 1'b0;
        end
      end
      GRANT: begin
        if (rel_norm || rel_to) begin
          state_nxt = TURN;
          gnt_nxt   = '0;
          id_nxt    = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = ID_W'((32'(id_q) + 1) % NUM_REQ);
          // A normal release on the same edge wins over the timeout.
          to_nxt    = rel_to && !rel_norm;
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
          hold_nxt  = hold_q + HOLD_W'(1);
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        id_nxt    = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_id   = id_q;
  assign bus.bus_busy = busy_q;
  assign bus.timeout  = to_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed, self-checking bench for bus_arbiter (NUM_REQ=4, MAX_HOLD=8).
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_bus_arbiter;
  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned MAX_HOLD = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_if ();

  bus_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus_if.req  = '0;
    bus_if.lock = '0;
    bus_if.done = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] gnt, input int id, input logic busy);
    check({tag, ".gnt"}, 32'(bus_if.gnt), 32'(gnt));
    check({tag, ".id"}, 32'(bus_if.gnt_id), 32'(id));
    check({tag, ".busy"}, 32'(bus_if.bus_busy), 32'(busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int cnt;
    n_tests = 0;
    n_fail  = 0;

    // Reset values, single request, done release with one dead cycle.
    do_reset();
    check_out("rst", 4'b0000, 0, 1'b0);
    check("rst.timeout", 32'(bus_if.timeout), 32'd0);
    bus_if.req = 4'b0001;
    tick();
    check_out("single.grant", 4'b0001, 0, 1'b1);
    bus_if.done = 4'b0001;
    bus_if.req  = 4'b0000;
    tick();
    bus_if.done = '0;
    check_out("single.release", 4'b0000, 0, 1'b0);
    tick();
    check_out("single.idle", 4'b0000, 0, 1'b0);

    // Round-robin rotation with all four requesting.
    do_reset();
    bus_if.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_out($sformatf("rr%0d.grant", k), 4'(1 << order[k]), order[k], 1'b1);
      tick();
      check($sformatf("rr%0d.hold", k), 32'(bus_if.gnt), 32'(1 << order[k]));
      bus_if.done = 4'(1 << order[k]);
      tick();
      bus_if.done = '0;
      check_out($sformatf("rr%0d.dead", k), 4'b0000, 0, 1'b0);
      tick();
    end
    check_out("rr.next", 4'b0010, 1, 1'b1);
    bus_if.req = '0;

    // Locked owner keeps the bus across done pulses.
    do_reset();
    bus_if.req = 4'b0100;
    tick();
    check_out("lock.grant", 4'b0100, 2, 1'b1);
    bus_if.lock = 4'b0100;
    bus_if.done = 4'b0100;
    tick();
    bus_if.done = '0;
    check("lock.done1", 32'(bus_if.gnt), 32'h4);
    tick();
    bus_if.done = 4'b0100;
    tick();
    bus_if.done = '0;
    check("lock.done2", 32'(bus_if.gnt), 32'h4);
    bus_if.lock = '0;
    bus_if.done = 4'b0100;
    tick();
    bus_if.done = '0;
    check_out("lock.release", 4'b0000, 0, 1'b0);
    bus_if.req = 4'b1001;
    tick();
    check_out("lock.ptr3", 4'b1000, 3, 1'b1);
    bus_if.req = '0;

    // Long hold: revoked after MAX_HOLD cycles only with the timeout feature.
    do_reset();
    bus_if.req = 4'b0110;
    tick();
    check_out("hold.grant", 4'b0010, 1, 1'b1);
`ifdef BUS_ARB_TIMEOUT_EN
    cnt = 0;
    while (bus_if.gnt[1] && cnt < 20) begin
      check("hold.no_to", 32'(bus_if.timeout), 32'd0);
      cnt++;
      tick();
    end
    check("hold.len", 32'(cnt), 32'(MAX_HOLD));
    check_out("hold.turn", 4'b0000, 0, 1'b0);
    check("hold.to_pulse", 32'(bus_if.timeout), 32'd1);
    tick();
    check_out("hold.next", 4'b0100, 2, 1'b1);
    check("hold.to_clear", 32'(bus_if.timeout), 32'd0);
`else
    cnt = 0;
    repeat (12) begin
      tick();
      cnt++;
    end
    check("hold.kept", 32'(bus_if.gnt), 32'h2);
    check("hold.no_to", 32'(bus_if.timeout), 32'd0);
    bus_if.done = 4'b0010;
    tick();
    bus_if.done = '0;
    check_out("hold.release", 4'b0000, 0, 1'b0);
    tick();
    check_out("hold.next", 4'b0100, 2, 1'b1);
`endif
    bus_if.req = '0;

    // Non-owner done ignored; owner drops req without done.
    do_reset();
    bus_if.req = 4'b1001;
    tick();
    check_out("drop.grant", 4'b0001, 0, 1'b1);
    bus_if.done = 4'b1000;
    tick();
    bus_if.done = '0;
    check("drop.foreign_done", 32'(bus_if.gnt), 32'h1);
    bus_if.req = 4'b1000;
    tick();
    check_out("drop.release", 4'b0000, 0, 1'b0);
    tick();
    check_out("drop.next", 4'b1000, 3, 1'b1);
    bus_if.req = '0;

    // Asynchronous reset mid-grant, pointer back to 0 afterwards.
    do_reset();
    bus_if.req = 4'b0100;
    tick();
    check_out("arst.grant", 4'b0100, 2, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_out("arst.drop", 4'b0000, 0, 1'b0);
    bus_if.req = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_out("arst.ptr0", 4'b0010, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single internal bus (MAR/RAM port) between the microcoded CPU controller and up to three auxiliary masters (program loader, DMA, debug port). It sequences ownership with a registered one-hot grant, enforces a one-cycle dead turnaround between owners so that no two masters ever drive the bus together, and optionally bounds how long any master may hold the bus. Requester 0 is the CPU controller by convention.

## Interface
- NUM_REQ, 4, number of requesters (2..8).
- MAX_HOLD, 8, maximum grant length in cycles when the timeout feature is compiled in (>=2).
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- REQ  input  NUM_REQ  per-requester bus request level; held high until served.
- LOCK  input  NUM_REQ  owner wants to keep the bus past DONE for back-to-back accesses.
- DONE  input  NUM_REQ  one-cycle pulse from the owner: transfer finished.
- GNT  output  NUM_REQ  registered one-hot grant; all-zero when no owner.
- GNT_ID  output  $clog2(NUM_REQ)  index of current owner; 0 when GNT is zero.
- BUS_BUSY  output  1  high exactly while GNT is non-zero.
- TIMEOUT  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- States: IDLE, GRANT, TURN. Reset: state IDLE, GNT=0, GNT_ID=0, BUS_BUSY=0, TIMEOUT=0, pointer=0, hold counter=0.
- Arbitration (in IDLE and TURN): winner = first i with REQ[i]=1 searching pointer, pointer+1, … modulo NUM_REQ. Winner loaded into GNT/GNT_ID, state → GRANT, hold counter cleared. No REQ: state → IDLE.
- GRANT, owner w: release when (DONE[w]=1 and LOCK[w]=0) or REQ[w]=0 or timeout. Otherwise stay, hold counter increments.
- DONE with LOCK[w]=1 keeps the grant; the hold counter is not cleared.
- On release: GNT=0, BUS_BUSY=0, pointer = (w+1) mod NUM_REQ, state → TURN.
- TURN: bus idle one cycle, then arbitrate as above (new grant visible after TURN's closing edge).
- REQ/LOCK/DONE of non-owners are ignored for release; REQ of non-owners only matters at arbitration.
- Reset asserted mid-grant: GNT drops to 0 immediately (asynchronous), pointer returns to 0; owner's transfer is abandoned.

## Timing
- REQ high before edge k in IDLE → GNT high after edge k (1-cycle latency).
- Release condition sampled at edge k → GNT low after edge k; earliest next grant after edge k+1 (exactly one dead cycle).
- Maximum grant length (timeout compiled in): MAX_HOLD cycles; counter reaching MAX_HOLD-1 at an edge forces release at that edge; TIMEOUT high during the following TURN cycle only.
- DONE and timeout on the same edge: treated as normal release, TIMEOUT not asserted.
- Outputs are all registered; the CPU controller samples GNT on its falling edge, half a cycle after update.
- Single requester continuously requesting with REQ dropped per transfer: grant every 2 cycles (GRANT, TURN).

## Configuration
- BUS_ARB_TIMEOUT_EN defined: hold counter and MAX_HOLD enforcement present, TIMEOUT driven as above.
- Not defined: no hold counter, a grant lasts until DONE without LOCK or REQ drop, TIMEOUT tied to 0, MAX_HOLD unused.

## Test plan
- Reset then REQ=0001 → GNT=0001, GNT_ID=0 one edge later; DONE[0] pulse → GNT=0000 next edge, BUS_BUSY low one cycle.
- REQ=1111 held, each owner pulses DONE after 2 cycles → grant order 0,1,2,3,0 with one dead cycle between each.
- Owner 2 with LOCK[2]=1 pulses DONE twice → grant kept; LOCK low then DONE → released, pointer=3 (REQ=1001 next grants 3).
- With BUS_ARB_TIMEOUT_EN, MAX_HOLD=8, owner 1 never pulses DONE → GNT[1] high exactly 8 cycles, TIMEOUT pulses once in TURN, next requester granted.
- Owner drops REQ without DONE → release on that edge; DONE pulse from non-owner 3 during another grant → no effect.
- RST low while GNT=0100 → GNT=0000 immediately without clock; after release REQ=0110 → requester 1 granted (pointer back at 0).
